// File: rtl/ntt_pkg.sv
// Shared types and constants for the INTT post-scale stage.
// Build-time widths come from DATA_WIDTH / NTT_STAGE_CNT / MUL_STAGE_CNT (Kyber defaults).
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif

package ntt_pkg;

  localparam int unsigned DATA_W     = `DATA_WIDTH;
  localparam int unsigned CNT_W      = `NTT_STAGE_CNT;
  localparam int unsigned MUL_STAGES = `MUL_STAGE_CNT;
  localparam int unsigned PAIRS      = 2 ** `NTT_STAGE_CNT;

  typedef logic [`DATA_WIDTH-1:0] coeff_t;

  typedef struct packed {
    coeff_t [1:0] c;
    logic         last;
  } pair_t;

  // Kyber modulus and Montgomery constants for R = 2^16
  localparam int unsigned Q_MOD    = 3329;
  localparam int unsigned QINV_NEG = 3327;  // -q^-1 mod 2^16

  localparam coeff_t DEFAULT_SCALE_CONST = coeff_t'(1441);

endpackage

// File: rtl/intt_post_fifo.sv
// Synchronous first-word-fall-through FIFO of coefficient pairs.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module intt_post_fifo
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pair_t wdata,
  input  logic  pop,
  output pair_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mo_mul.sv
// Pipelined Montgomery multiplier: res = a*b*2^-16 mod q, result always < q.
// Latency is Stages cycles from a/b to res.
module mo_mul
  import ntt_pkg::*;
#(
  parameter int unsigned Stages = MUL_STAGES
) (
  input  logic   clk,
  input  logic   rst,
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t res
);

  logic [31:0] prod;
  logic [31:0] m_full;
  logic [31:0] t;
  coeff_t      red;
  coeff_t      pipe_q [Stages];

  always_comb begin
    prod   = 32'(a) * 32'(b);
    m_full = {16'b0, prod[15:0]} * 32'(QINV_NEG);
    // prod < 2^24 and m*q < 2^28, so the sum cannot overflow 32 bits
    t      = (prod + {16'b0, m_full[15:0]} * 32'(Q_MOD)) >> 16;
    red    = (t >= 32'(Q_MOD)) ? coeff_t'(t - 32'(Q_MOD)) : coeff_t'(t);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Stages); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= red;
      for (int i = 1; i < int'(Stages); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign res = pipe_q[Stages-1];

endmodule

// File: rtl/intt_post_scale.sv
// Scales the final INTT coefficient pairs by SCALE_CONST and buffers them for a ready/valid consumer.
// Define INTT_POST_SCALE_EN to enable the multipliers; otherwise lanes pass through a matched delay.
module intt_post_scale
  import ntt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter coeff_t      SCALE_CONST = DEFAULT_SCALE_CONST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_en,
  input  logic [1:0][`DATA_WIDTH-1:0]  in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0][`DATA_WIDTH-1:0]  out,
  output logic                         out_last,
  output logic                         busy,
  output logic                         ovf
);

  logic [MUL_STAGES-1:0] valid_pipe_q;
  logic [CNT_W-1:0]      in_cnt_q;
  logic                  ovf_q;
  coeff_t                res [2];
  logic                  push;
  pair_t                 wdata, rdata;
  logic                  full, empty;

`ifdef INTT_POST_SCALE_EN
  for (genvar k = 0; k < 2; k++) begin : g_mul
    mo_mul #(
      .Stages (MUL_STAGES)
    ) u_mo_mul (
      .clk (clk),
      .rst (rst),
      .a   (SCALE_CONST),
      .b   (in[k]),
      .res (res[k])
    );
  end
`else
  // Delay line matches multiplier latency so framing and timing are unchanged
  coeff_t dly_q [MUL_STAGES][2];
  logic   unused_scale;

  assign unused_scale = ^SCALE_CONST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MUL_STAGES); i++) begin
        dly_q[i][0] <= '0;
        dly_q[i][1] <= '0;
      end
    end else begin
      dly_q[0][0] <= in[0];
      dly_q[0][1] <= in[1];
      for (int i = 1; i < int'(MUL_STAGES); i++) begin
        dly_q[i][0] <= dly_q[i-1][0];
        dly_q[i][1] <= dly_q[i-1][1];
      end
    end
  end

  assign res[0] = dly_q[MUL_STAGES-1][0];
  assign res[1] = dly_q[MUL_STAGES-1][1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_pipe_q <= '0;
    end else begin
      valid_pipe_q[0] <= in_en;
      for (int i = 1; i < int'(MUL_STAGES); i++) valid_pipe_q[i] <= valid_pipe_q[i-1];
    end
  end

  assign push = valid_pipe_q[MUL_STAGES-1];

  always_comb begin
    wdata      = '0;
    wdata.c[0] = res[0];
    wdata.c[1] = res[1];
    wdata.last = &in_cnt_q;
  end

  // in_cnt advances on dropped pushes too, so block framing survives an overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) in_cnt_q <= in_cnt_q + CNT_W'(1);
      if (push && full && !out_ready) ovf_q <= 1'b1;
    end
  end

  intt_post_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (out_ready),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out       = rdata.c;
  assign out_last  = rdata.last && !empty;
  assign busy      = (|valid_pipe_q) || !empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_intt_post_scale.sv
// Directed self-checking bench for intt_post_scale (expects Kyber q = 3329 when scaling is built in).
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif

module tb_intt_post_scale;

  localparam int DW    = `DATA_WIDTH;
  localparam int MUL   = `MUL_STAGE_CNT;
  localparam int NP    = 2 ** `NTT_STAGE_CNT;
  localparam int DEPTH = 8;
  localparam int Q     = 3329;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_en = 1'b0;
  logic                out_ready = 1'b0;
  logic [1:0][DW-1:0]  in_d = '0;
  logic [1:0][DW-1:0]  out_d;
  logic                out_valid, out_last, busy, ovf;

  always #5 clk = ~clk;

  intt_post_scale #(
    .FIFO_DEPTH  (DEPTH),
    .SCALE_CONST (12'd1441)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in        (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_d),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
  );

  typedef struct {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tb_cnt   = 0;
  int   n_last   = 0;

  // mont(1441*x) = 1441*x*2^-16 mod q, and 2^-16 mod 3329 = 169
  function automatic logic [DW-1:0] model(input int x);
    logic [DW-1:0] r;
`ifdef INTT_POST_SCALE_EN
    r = DW'((longint'(x) * 1441 * 169) % Q);
`else
    r = DW'(x);
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer-side scoreboard: sampled on the falling edge, handshake completes on the next rise
  logic [1:0][DW-1:0] prev_out;
  logic               prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("out_hold", 64'(out_d), 64'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pop", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_lane0", 64'(out_d[0]), 64'(e.c0));
          check("out_lane1", 64'(out_d[1]), 64'(e.c1));
          check("out_last", 64'(out_last), 64'(e.last));
          if (out_last) n_last++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out_d;
    end
  end

  // Drive n pairs back to back; only the first 'keep' are expected at the output.
  task automatic send(input int n, input int pat, input int keep, input int off_i,
                      input int on_i, input bit chk_lat);
    int x, y;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == off_i) out_ready = 1'b0;
      if (i == on_i) out_ready = 1'b1;
      if (chk_lat && i == MUL) check("lat_not_early", 64'(out_valid), 64'(0));
      if (chk_lat && i == MUL + 1) check("lat_valid", 64'(out_valid), 64'(1));
      if (pat == 0) begin
        x = 1;
        y = Q - 1;
      end else begin
        x = (i * pat + 7) % Q;
        y = (Q - 1 - ((i * 13 + pat * 101) % Q));
      end
      in_d[0] = DW'(x);
      in_d[1] = DW'(y);
      in_en   = 1'b1;
      if (i < keep) exp_q.push_back('{model(x), model(y), (tb_cnt == NP - 1)});
      tb_cnt = (tb_cnt + 1) % NP;
    end
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_idle", 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_en = 1'b0;
    exp_q.delete();
    tb_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int lasts0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    rst = 1'b1;

    // Test 1: reset mid-stream discards everything in flight
    out_ready = 1'b0;
    for (int i = 0; i < MUL + 2; i++) begin
      @(posedge clk);
      #1;
      in_d[0] = DW'(i + 3);
      in_d[1] = DW'(i + 9);
      in_en   = 1'b1;
    end
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_last", 64'(out_last), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ovf", 64'(ovf), 64'(0));
    in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (MUL + 2) @(posedge clk);
    #1;
    check("post_rst_valid", 64'(out_valid), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));

    // Test 2: single block, consumer always ready, latency and framing
    out_ready = 1'b1;
    send(NP, 0, NP, -1, -1, 1'b1);
    drain();
    check("t2_ovf", 64'(ovf), 64'(0));

    // Test 3: 5-cycle stall mid-block fits in the FIFO
    send(NP, 1, NP, 40, 45, 1'b0);
    drain();
    check("t3_ovf", 64'(ovf), 64'(0));

    // Test 4: consumer stalled for a whole block -> first DEPTH pairs kept, ovf sticky
    out_ready = 1'b0;
    send(NP, 2, DEPTH, -1, -1, 1'b0);
    repeat (MUL + 2) @(posedge clk);
    #1;
    check("t4_ovf_set", 64'(ovf), 64'(1));
    check("t4_full_valid", 64'(out_valid), 64'(1));
    drain();
    check("t4_ovf_held", 64'(ovf), 64'(1));
    send(NP, 3, NP, -1, -1, 1'b0);
    drain();
    check("t4_ovf_sticky", 64'(ovf), 64'(1));
    do_reset();
    check("t4_ovf_cleared", 64'(ovf), 64'(0));

    // Test 5: FIFO fills to DEPTH, then push and pop coincide every cycle
    out_ready = 1'b0;
    send(NP, 4, NP, -1, DEPTH + MUL, 1'b0);
    drain();
    check("t5_ovf", 64'(ovf), 64'(0));

    // Test 6: two blocks back to back
    lasts0 = n_last;
    out_ready = 1'b1;
    send(2 * NP, 5, 2 * NP, -1, -1, 1'b1);
    drain();
    check("t6_last_count", 64'(n_last - lasts0), 64'(2));
    check("t6_ovf", 64'(ovf), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
